// File: rtl/mcu_dma_sched.sv
// -----------------------------------------------------------------------------
// mcu_dma_sched
//   Bus-slot scheduler shared by NCH DMA channels and the CPU. Each channel
//   has its own word pointer, an inclusive end compare, frame repeat, stop
//   and end-of-frame interrupt. On every slot_en strobe one owner is picked:
//   a pending DMA channel first, then the CPU, otherwise the slot stays idle.
//
//   Build option: define MCU_DMA_RR_EN for round-robin DMA arbitration. The
//   search starts after the last granted channel, and the last-grant register
//   resets to NCH-1 so that channel 0 is favoured first. When the macro is
//   undefined, fixed priority applies and the lowest index wins.
//
// Ports
//   clk32      system clock
//   porb       asynchronous active-low reset
//   slot_en    one-clk32 strobe marking the start of a bus slot
//   cpu_req    CPU access pending
//   ch_on      per-channel enable (a rising edge starts the channel)
//   ch_rep     per-channel repeat (frame wrap) mode
//   ch_req     per-channel data request
//   ch_start   start pointers, channel i at [i*AW +: AW]
//   ch_end     inclusive end pointers, same packing as ch_start
//   cpu_cyc    CPU owns the current slot
//   dma_cyc    one-hot DMA owner of the current slot
//   dma_addr   word address for the DMA slot (holds its value when idle)
//   dma_load   one-clk32 strobe telling channel i to latch the data
//   ch_active  channel running
//   ch_frame   toggles on every frame wrap
//   ch_irq     one-clk32 end-of-frame pulse
//   ch_ptr     current pointers (readback)
// -----------------------------------------------------------------------------
module mcu_dma_sched #(
  parameter int AW  = 21,
  parameter int NCH = 2
) (
  input  logic              clk32,
  input  logic              porb,
  input  logic              slot_en,
  input  logic              cpu_req,
  input  logic [NCH-1:0]    ch_on,
  input  logic [NCH-1:0]    ch_rep,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_start,
  input  logic [NCH*AW-1:0] ch_end,
  output logic              cpu_cyc,
  output logic [NCH-1:0]    dma_cyc,
  output logic [AW-1:0]     dma_addr,
  output logic [NCH-1:0]    dma_load,
  output logic [NCH-1:0]    ch_active,
  output logic [NCH-1:0]    ch_frame,
  output logic [NCH-1:0]    ch_irq,
  output logic [NCH*AW-1:0] ch_ptr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  logic [NCH-1:0] run_vec;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] grant_vec;     // one-hot winner, already qualified by slot_en
  logic           grant_found;
  logic           cpu_grant;
  logic [AW-1:0]  addr_sel;

  logic           cpu_cyc_reg;
  logic [NCH-1:0] dma_cyc_reg;
  logic [NCH-1:0] dma_load_reg;
  logic [AW-1:0]  dma_addr_reg;

  // A channel that loses ch_on in the strobe cycle drops out of pending here.
  assign pending = run_vec & ch_on & ch_req;

`ifdef MCU_DMA_RR_EN
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
  logic [LW-1:0] last_grant_reg;
  logic [LW-1:0] grant_idx;

  always_comb begin
    int idx;
    idx         = 0;
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(last_grant_reg) + 1 + k) % NCH;
      if (!grant_found && pending[idx]) begin
        grant_found    = 1'b1;
        grant_vec[idx] = 1'b1;
        grant_idx      = LW'(idx);
      end
    end
    if (!slot_en) begin
      grant_vec   = '0;
      grant_found = 1'b0;
    end
  end

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      last_grant_reg <= LW'(NCH - 1);
    end else if (grant_found) begin
      last_grant_reg <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_found && pending[k]) begin
        grant_found  = 1'b1;
        grant_vec[k] = 1'b1;
      end
    end
    if (!slot_en) begin
      grant_vec   = '0;
      grant_found = 1'b0;
    end
  end
`endif

  assign cpu_grant = slot_en & ~grant_found & cpu_req;

  // Pre-increment pointer of the winning channel.
  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_vec[k]) begin
        addr_sel = ch_ptr[k*AW +: AW];
      end
    end
  end

  // Slot ownership is only re-evaluated on a strobe; dma_load is a pulse.
  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      cpu_cyc_reg  <= 1'b0;
      dma_cyc_reg  <= '0;
      dma_load_reg <= '0;
      dma_addr_reg <= '0;
    end else begin
      dma_load_reg <= grant_vec;
      if (slot_en) begin
        cpu_cyc_reg <= cpu_grant;
        dma_cyc_reg <= grant_vec;
        if (grant_found) begin
          dma_addr_reg <= addr_sel;
        end
      end
    end
  end

  assign cpu_cyc  = cpu_cyc_reg;
  assign dma_cyc  = dma_cyc_reg;
  assign dma_load = dma_load_reg;
  assign dma_addr = dma_addr_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_t     state_reg, state_next;
      logic [AW-1:0] ptr_reg, ptr_next;
      logic          on_d_reg;
      logic          frame_reg, frame_next;
      logic          irq_reg, irq_next;
      logic          active_reg, active_next;
      logic [AW-1:0] start_w, end_w;

      assign start_w = ch_start[gi*AW +: AW];
      assign end_w   = ch_end[gi*AW +: AW];

      always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        frame_next  = frame_reg;
        irq_next    = 1'b0;
        active_next = active_reg;
        if (!ch_on[gi]) begin
          // Stop from any state; the pointer keeps its last value.
          state_next  = ST_IDLE;
          active_next = 1'b0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (!on_d_reg) begin
                state_next  = ST_RUN;
                ptr_next    = start_w;
                active_next = 1'b1;
              end
            end
            ST_RUN: begin
              if (grant_vec[gi]) begin
                if (ptr_reg != end_w) begin
                  ptr_next = ptr_reg + AW'(1);
                end else begin
                  irq_next = 1'b1;
                  if (ch_rep[gi]) begin
                    ptr_next   = start_w;
                    frame_next = ~frame_reg;
                  end else begin
                    state_next  = ST_DONE;
                    active_next = 1'b0;
                  end
                end
              end
            end
            ST_DONE: ;
            default: state_next = ST_IDLE;
          endcase
        end
      end

      // on_d resets high: a channel whose enable is held through reset must
      // see a fresh 0->1 transition before it starts again.
      always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
          state_reg  <= ST_IDLE;
          ptr_reg    <= '0;
          on_d_reg   <= 1'b1;
          frame_reg  <= 1'b0;
          irq_reg    <= 1'b0;
          active_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          ptr_reg    <= ptr_next;
          on_d_reg   <= ch_on[gi];
          frame_reg  <= frame_next;
          irq_reg    <= irq_next;
          active_reg <= active_next;
        end
      end

      assign run_vec[gi]            = (state_reg == ST_RUN);
      assign ch_ptr[gi*AW +: AW]    = ptr_reg;
      assign ch_active[gi]          = active_reg;
      assign ch_frame[gi]           = frame_reg;
      assign ch_irq[gi]             = irq_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mcu_dma_sched.sv
// -----------------------------------------------------------------------------
// tb_mcu_dma_sched
//   Directed bench for mcu_dma_sched (AW=21, NCH=2). Inputs change on the
//   falling edge of clk32, outputs are checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mcu_dma_sched;
  localparam int AW  = 21;
  localparam int NCH = 2;

  logic              clk32 = 1'b0;
  logic              porb;
  logic              slot_en;
  logic              cpu_req;
  logic [NCH-1:0]    ch_on;
  logic [NCH-1:0]    ch_rep;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_start;
  logic [NCH*AW-1:0] ch_end;
  logic              cpu_cyc;
  logic [NCH-1:0]    dma_cyc;
  logic [AW-1:0]     dma_addr;
  logic [NCH-1:0]    dma_load;
  logic [NCH-1:0]    ch_active;
  logic [NCH-1:0]    ch_frame;
  logic [NCH-1:0]    ch_irq;
  logic [NCH*AW-1:0] ch_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk32 = ~clk32;

  mcu_dma_sched #(.AW(AW), .NCH(NCH)) dut (
    .clk32     (clk32),
    .porb      (porb),
    .slot_en   (slot_en),
    .cpu_req   (cpu_req),
    .ch_on     (ch_on),
    .ch_rep    (ch_rep),
    .ch_req    (ch_req),
    .ch_start  (ch_start),
    .ch_end    (ch_end),
    .cpu_cyc   (cpu_cyc),
    .dma_cyc   (dma_cyc),
    .dma_addr  (dma_addr),
    .dma_load  (dma_load),
    .ch_active (ch_active),
    .ch_frame  (ch_frame),
    .ch_irq    (ch_irq),
    .ch_ptr    (ch_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk32);
  endtask

  // One strobe; returns on the falling edge after the grant was registered.
  task automatic slot();
    slot_en = 1'b1;
    @(negedge clk32);
    slot_en = 1'b0;
    $display("slot: cpu=%b dma=%b addr=%06h load=%b irq=%b frame=%b",
             cpu_cyc, dma_cyc, dma_addr, dma_load, ch_irq, ch_frame);
  endtask

  task automatic chk_dma(input string tag, input logic [1:0] own, input logic [20:0] addr);
    chk({tag, "_cyc"},  32'(dma_cyc),  32'(own));
    chk({tag, "_load"}, 32'(dma_load), 32'(own));
    chk({tag, "_addr"}, 32'(dma_addr), 32'(addr));
    chk({tag, "_cpu"},  32'(cpu_cyc),  32'd0);
  endtask

  initial begin
    porb = 1'b0; slot_en = 1'b0; cpu_req = 1'b0;
    ch_on = '0; ch_rep = '0; ch_req = '0; ch_start = '0; ch_end = '0;
    cyc(2);
    chk("rst_cpu", 32'(cpu_cyc), 0);
    chk("rst_dma", 32'(dma_cyc), 0);
    chk("rst_addr", 32'(dma_addr), 0);
    chk("rst_act", 32'(ch_active), 0);
    chk("rst_ptr0", 32'(ch_ptr[0 +: AW]), 0);
    porb = 1'b1;
    cyc(1);

    // --- single frame, no repeat
    ch_start[0 +: AW] = 21'h100; ch_end[0 +: AW] = 21'h102;
    ch_req = 2'b01; cpu_req = 1'b1;
    ch_on = 2'b01;
    cyc(1);
    chk("t1_act", 32'(ch_active), 32'h1);
    chk("t1_ptr", 32'(ch_ptr[0 +: AW]), 32'h100);
    slot(); chk_dma("t1_s0", 2'b01, 21'h100); cyc(3);
    slot(); chk_dma("t1_s1", 2'b01, 21'h101); cyc(3);
    slot(); chk_dma("t1_s2", 2'b01, 21'h102);
    chk("t1_irq", 32'(ch_irq), 32'h1);
    chk("t1_act_off", 32'(ch_active), 0);
    chk("t1_ptr_end", 32'(ch_ptr[0 +: AW]), 32'h102);
    cyc(1);
    chk("t1_irq_clr", 32'(ch_irq), 0);
    chk("t1_held", 32'(dma_cyc), 32'h1);
    chk("t1_load_clr", 32'(dma_load), 0);
    cyc(2);
    slot();
    chk("t1_cpu", 32'(cpu_cyc), 1);
    chk("t1_cpu_dma", 32'(dma_cyc), 0);
    chk("t1_addr_hold", 32'(dma_addr), 32'h102);

    // --- wrapping frame with repeat
    ch_on = 2'b00; cyc(1);
    ch_start[0 +: AW] = 21'h1FFFFE; ch_end[0 +: AW] = 21'h000001; ch_rep = 2'b01;
    ch_on = 2'b01; cyc(1);
    slot(); chk_dma("t2_s0", 2'b01, 21'h1FFFFE); chk("t2_irq0", 32'(ch_irq), 0); cyc(1);
    slot(); chk_dma("t2_s1", 2'b01, 21'h1FFFFF); cyc(1);
    slot(); chk_dma("t2_s2", 2'b01, 21'h000000); chk("t2_frm2", 32'(ch_frame), 0); cyc(1);
    slot(); chk_dma("t2_s3", 2'b01, 21'h000001);
    chk("t2_irq3", 32'(ch_irq), 32'h1);
    chk("t2_frm3", 32'(ch_frame), 32'h1);
    cyc(1);
    slot(); chk_dma("t2_s4", 2'b01, 21'h1FFFFE);
    chk("t2_irq4", 32'(ch_irq), 0);
    chk("t2_frm4", 32'(ch_frame), 32'h1);

    // --- two channels competing with the CPU
    ch_on = 2'b00; cyc(1);
    ch_start[0 +: AW] = 21'h200; ch_end[0 +: AW] = 21'h2FF;
    ch_start[AW +: AW] = 21'h300; ch_end[AW +: AW] = 21'h3FF;
    ch_rep = 2'b11; ch_req = 2'b11; cpu_req = 1'b1;
    ch_on = 2'b11; cyc(1);
`ifdef MCU_DMA_RR_EN
    slot(); chk_dma("t3_s0", 2'b10, 21'h300); cyc(1);
    slot(); chk_dma("t3_s1", 2'b01, 21'h200); cyc(1);
    slot(); chk_dma("t3_s2", 2'b10, 21'h301); cyc(1);
    ch_req = 2'b10;
    slot(); chk_dma("t3_s3", 2'b10, 21'h302); cyc(1);
`else
    slot(); chk_dma("t3_s0", 2'b01, 21'h200); cyc(1);
    slot(); chk_dma("t3_s1", 2'b01, 21'h201); cyc(1);
    slot(); chk_dma("t3_s2", 2'b01, 21'h202); cyc(1);
    ch_req = 2'b10;
    slot(); chk_dma("t3_s3", 2'b10, 21'h300); cyc(1);
`endif
    ch_req = 2'b00;
    slot();
    chk("t3_cpu", 32'(cpu_cyc), 1);
    chk("t3_cpu_dma", 32'(dma_cyc), 0);
    cyc(1);

    // --- ch_on[0] drops in the strobe cycle
    ch_req = 2'b11;
    ch_on = 2'b10;
`ifdef MCU_DMA_RR_EN
    slot(); chk_dma("t4_s", 2'b10, 21'h303);
    chk("t4_ptr0", 32'(ch_ptr[0 +: AW]), 32'h201);
`else
    slot(); chk_dma("t4_s", 2'b10, 21'h301);
    chk("t4_ptr0", 32'(ch_ptr[0 +: AW]), 32'h203);
`endif
    chk("t4_act", 32'(ch_active), 32'h2);
    ch_on = 2'b11; cyc(1);
    chk("t4_reload", 32'(ch_ptr[0 +: AW]), 32'h200);
    chk("t4_act_on", 32'(ch_active), 32'h3);

    // --- asynchronous reset in the middle of a DMA slot
    slot(); chk_dma("t5_s", 2'b01, 21'h200);
    porb = 1'b0;
    #1;
    chk("t5_rst_dma", 32'(dma_cyc), 0);
    chk("t5_rst_addr", 32'(dma_addr), 0);
    chk("t5_rst_act", 32'(ch_active), 0);
    chk("t5_rst_ptr0", 32'(ch_ptr[0 +: AW]), 0);
    cyc(1);
    porb = 1'b1; cpu_req = 1'b0;
    cyc(1);
    slot();
    chk("t5_no_grant", 32'(dma_cyc), 0);
    chk("t5_no_cpu", 32'(cpu_cyc), 0);
    chk("t5_idle_act", 32'(ch_active), 0);
    ch_on = 2'b00; cyc(1);
    ch_on = 2'b01; cyc(1);
    chk("t5_restart", 32'(ch_ptr[0 +: AW]), 32'h200);
    chk("t5_restart_act", 32'(ch_active), 32'h1);

    // --- one-word frame, back-to-back strobes
    ch_on = 2'b00; cyc(1);
    ch_start[0 +: AW] = 21'h050; ch_end[0 +: AW] = 21'h050;
    ch_rep = 2'b01; ch_req = 2'b01; cpu_req = 1'b1;
    ch_on = 2'b01; cyc(1);
    slot_en = 1'b1;
    @(negedge clk32);
    $display("slot: cpu=%b dma=%b addr=%06h load=%b irq=%b frame=%b",
             cpu_cyc, dma_cyc, dma_addr, dma_load, ch_irq, ch_frame);
    chk_dma("t6_s0", 2'b01, 21'h050);
    chk("t6_irq0", 32'(ch_irq), 32'h1);
    chk("t6_frm0", 32'(ch_frame), 32'h1);
    slot();
    chk_dma("t6_s1", 2'b01, 21'h050);
    chk("t6_irq1", 32'(ch_irq), 32'h1);
    chk("t6_frm1", 32'(ch_frame), 32'h0);
    cyc(1);
    chk("t6_irq_clr", 32'(ch_irq), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
